// File: rtl/cci_mpf_prim_fifo_rr_sched.sv
// Round-robin scheduler draining N_CHANNELS upstream FIFOs into one output
// stream. Once a channel starts a multi-beat packet it keeps the grant until
// the end-of-packet beat has been dequeued. The output beat is registered, so
// a grant in cycle t appears on out_* in cycle t+1.

module cci_mpf_prim_fifo_rr_sched #(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned N_DATA_BITS = 32,
  localparam int unsigned ChanW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [N_CHANNELS-1:0]                  in_notEmpty,
  input  logic [N_CHANNELS-1:0][N_DATA_BITS-1:0] in_first,
  input  logic [N_CHANNELS-1:0]                  in_eop,
  output logic [N_CHANNELS-1:0]                  in_deq,

  input  logic                                   out_almostFull,
  output logic                                   out_valid,
  output logic [N_DATA_BITS-1:0]                 out_data,
  output logic                                   out_eop,
  output logic [ChanW-1:0]                       out_chan
);

  typedef enum logic {
    StArb,
    StLocked
  } state_e;

  state_e           state_q;
  logic [ChanW-1:0] ptr_q;
  logic [ChanW-1:0] lock_chan_q;

  logic             grant_valid;
  logic [ChanW-1:0] grant_chan;
  logic             grant_eop;
  logic [ChanW-1:0] ptr_after_grant;

  // Rotating search candidate; wider than ChanW so ptr + offset cannot overflow.
  int unsigned      cand;
  logic [ChanW-1:0] cand_chan;

  // Grant selection: locked channel only, or first non-empty channel from ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_chan  = '0;
    cand        = 0;
    cand_chan   = '0;
    if (!reset && !out_almostFull) begin
      if (state_q == StLocked) begin
        // Hold the lock even when its FIFO is momentarily empty.
        grant_valid = in_notEmpty[lock_chan_q];
        grant_chan  = lock_chan_q;
      end else begin
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
          cand = 32'(ptr_q) + i;
          if (cand >= N_CHANNELS) begin
            cand = cand - N_CHANNELS;
          end
          cand_chan = ChanW'(cand);
          if (!grant_valid && in_notEmpty[cand_chan]) begin
            grant_valid = 1'b1;
            grant_chan  = cand_chan;
          end
        end
      end
    end
  end

  // Dequeue strobe is the one-hot decode of the grant.
  always_comb begin
    in_deq = '0;
    if (grant_valid) begin
      in_deq[grant_chan] = 1'b1;
    end
  end

  // Pointer advances past the channel whose packet just completed.
  always_comb begin
    grant_eop = in_eop[grant_chan];
    if (grant_chan == ChanW'(N_CHANNELS - 1)) begin
      ptr_after_grant = '0;
    end else begin
      ptr_after_grant = grant_chan + ChanW'(1);
    end
  end

  // Arbitration FSM, pointer, lock channel and registered output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StArb;
      ptr_q       <= '0;
      lock_chan_q <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_eop     <= 1'b0;
      out_chan    <= '0;
    end else begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= in_first[grant_chan];
        out_eop  <= grant_eop;
        out_chan <= grant_chan;
        if (grant_eop) begin
          state_q <= StArb;
          ptr_q   <= ptr_after_grant;
        end else begin
          state_q     <= StLocked;
          lock_chan_q <= grant_chan;
        end
      end
    end
  end

  // Dequeue must be one-hot or zero and only for channels holding data.
  a_deq_onehot : assert property (@(posedge clk) $onehot0(in_deq));
  a_deq_has_data : assert property (@(posedge clk) (in_deq & ~in_notEmpty) == '0);

endmodule

// File: tb/tb_cci_mpf_prim_fifo_rr_sched.sv
// Bench for the round-robin FIFO scheduler: a directed vector table followed by
// randomized traffic, all checked against a packet-level reference model.

module tb_cci_mpf_prim_fifo_rr_sched;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NCH-1:0]           in_notEmpty;
  logic [NCH-1:0][DW-1:0]   in_first;
  logic [NCH-1:0]           in_eop;
  logic [NCH-1:0]           in_deq;
  logic                     out_almostFull;
  logic                     out_valid;
  logic [DW-1:0]            out_data;
  logic                     out_eop;
  logic [1:0]               out_chan;

  cci_mpf_prim_fifo_rr_sched #(
    .N_CHANNELS (NCH),
    .N_DATA_BITS(DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_notEmpty   (in_notEmpty),
    .in_first      (in_first),
    .in_eop        (in_eop),
    .in_deq        (in_deq),
    .out_almostFull(out_almostFull),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_eop       (out_eop),
    .out_chan      (out_chan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: packet-level view of the scheduler.
  int      m_ptr = 0;
  bit      m_locked = 0;
  int      m_lock = 0;
  bit      m_known = 0;
  bit      m_exp_valid = 0;
  logic [DW-1:0] m_exp_data;
  bit      m_exp_eop;
  int      m_exp_chan;

  // Values sampled during the last tick, for the vector table.
  logic [NCH-1:0] s_deq;
  logic           s_valid;
  logic [1:0]     s_chan;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant(input logic rst, input logic [NCH-1:0] ne, input logic af);
    if (rst || af) return -1;
    if (m_locked) return ne[m_lock] ? m_lock : -1;
    for (int k = 0; k < NCH; k++) begin
      if (ne[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check just after, return at next negedge.
  task automatic tick(input logic rst, input logic [NCH-1:0] ne, input logic [NCH-1:0] eop,
                      input logic af);
    int g;
    logic [NCH-1:0] exp_deq;
    reset          = rst;
    in_notEmpty    = ne;
    in_eop         = eop;
    out_almostFull = af;
    for (int c = 0; c < NCH; c++) begin
      in_first[c] = {cyc[23:0], 4'(c), 4'h5} ^ $urandom;
    end
    #1;
    s_deq   = in_deq;
    s_valid = out_valid;
    s_chan  = out_chan;
    g = model_grant(rst, ne, af);
    exp_deq = (g < 0) ? '0 : (NCH'(1) << g);
    chk("in_deq", 64'(in_deq), 64'(exp_deq));
    if (m_known) begin
      chk("out_valid", 64'(out_valid), 64'(m_exp_valid));
      if (m_exp_valid) begin
        chk("out_data", 64'(out_data), 64'(m_exp_data));
        chk("out_eop", 64'(out_eop), 64'(m_exp_eop));
        chk("out_chan", 64'(out_chan), 64'(m_exp_chan));
      end
    end
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_lock = 0; m_exp_valid = 0; m_known = 1;
    end else if (g >= 0) begin
      m_exp_valid = 1;
      m_exp_data  = in_first[g];
      m_exp_eop   = eop[g];
      m_exp_chan  = g;
      if (eop[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % NCH;
      end else begin
        m_locked = 1;
        m_lock   = g;
      end
    end else begin
      m_exp_valid = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic           rst;
    logic [NCH-1:0] ne;
    logic [NCH-1:0] eop;
    logic           af;
    logic [NCH-1:0] exp_deq;
    logic           chk_out;
    logic           exp_valid;
    logic [1:0]     exp_chan;
  } vec_t;

  vec_t vecs[29];

  initial begin
    reset = 1'b1; in_notEmpty = '0; in_first = '0; in_eop = '0; out_almostFull = 1'b0;

    // rst, notEmpty, eop, almostFull | in_deq, check out, out_valid, out_chan
    vecs[0]  = '{1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0};
    // Strict rotation of single-beat packets after reset
    vecs[1]  = '{0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 0, 0};
    vecs[2]  = '{0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 0};
    vecs[3]  = '{0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 1};
    vecs[4]  = '{0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 1, 2};
    vecs[5]  = '{0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 3};
    // Back-pressure for 3 cycles; pointer holds at 1
    vecs[6]  = '{0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 1, 0};
    vecs[7]  = '{0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 0};
    vecs[8]  = '{0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 0};
    vecs[9]  = '{0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 0, 0};
    vecs[10] = '{0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 1};
    // Only channel 3 has data: granted every cycle, pointer wraps to 0
    vecs[11] = '{0, 4'b1000, 4'b1111, 0, 4'b1000, 1, 1, 2};
    vecs[12] = '{0, 4'b1000, 4'b1111, 0, 4'b1000, 1, 1, 3};
    vecs[13] = '{0, 4'b1000, 4'b1111, 0, 4'b1000, 1, 1, 3};
    vecs[14] = '{0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 1, 3};
    vecs[15] = '{0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 0, 0};
    // Move ptr to 1, then 3-beat packet on channel 1
    vecs[16] = '{0, 4'b0001, 4'b1111, 0, 4'b0001, 1, 0, 0};
    vecs[17] = '{0, 4'b0111, 4'b0101, 0, 4'b0010, 1, 1, 0};
    vecs[18] = '{0, 4'b0111, 4'b0101, 0, 4'b0010, 1, 1, 1};
    vecs[19] = '{0, 4'b0111, 4'b0111, 0, 4'b0010, 1, 1, 1};
    vecs[20] = '{0, 4'b0111, 4'b1111, 0, 4'b0100, 1, 1, 1};
    vecs[21] = '{0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 1, 2};
    // Lock on channel 2, which then runs dry for 2 cycles
    vecs[22] = '{0, 4'b0100, 4'b1011, 0, 4'b0100, 1, 0, 0};
    vecs[23] = '{0, 4'b1011, 4'b1111, 0, 4'b0000, 1, 1, 2};
    vecs[24] = '{0, 4'b1011, 4'b1111, 0, 4'b0000, 1, 0, 0};
    vecs[25] = '{0, 4'b1111, 4'b1011, 0, 4'b0100, 1, 0, 0};
    // Reset while still locked on 2: lock abandoned, channel 0 next
    vecs[26] = '{1, 4'b1111, 4'b1011, 0, 4'b0000, 1, 1, 2};
    vecs[27] = '{0, 4'b0001, 4'b1111, 0, 4'b0001, 1, 0, 0};
    vecs[28] = '{0, 4'b0000, 4'b1111, 0, 4'b0000, 1, 1, 0};

    @(negedge clk);

    for (int i = 0; i < 29; i++) begin
      tick(vecs[i].rst, vecs[i].ne, vecs[i].eop, vecs[i].af);
      chk($sformatf("vec%0d_deq", i), 64'(s_deq), 64'(vecs[i].exp_deq));
      if (vecs[i].chk_out) begin
        chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          chk($sformatf("vec%0d_chan", i), 64'(s_chan), 64'(vecs[i].exp_chan));
        end
      end
    end

    // Sustained 6-beat packet on channel 3 while others stay full
    tick(1, 4'b0000, 4'b0000, 0);
    for (int b = 0; b < 6; b++) begin
      tick(0, 4'b1111, (b == 5) ? 4'b1111 : 4'b0111, 0);
      chk($sformatf("burst%0d_deq", b), 64'(s_deq), (b == 0) ? 64'h1 : 64'h8);
      if (b == 0) begin
        // Channel 0 single beat first, then ptr=1..: channel 1 eop, so rewrite
        tick(1, 4'b0000, 4'b0000, 0);
        tick(0, 4'b1000, 4'b0111, 0);
        chk("burst_lock3_deq", 64'(s_deq), 64'h8);
      end
    end
    tick(0, 4'b0000, 4'b1111, 0);
    chk("burst_end_valid", 64'(s_valid), 64'h1);
    chk("burst_end_chan", 64'(s_chan), 64'h3);

    // Randomized traffic against the model
    for (int r = 0; r < 3000; r++) begin
      tick(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           NCH'($urandom),
           NCH'($urandom | $urandom),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
